// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// Purpose
//   Multicycle signed 32-bit multiplier / divider for the execute stage.
//   - Multiply: 32-step shift-add on operand magnitudes, with the sign applied
//     to the full 64-bit product at the end.
//   - Divide: 32-step restoring divide on magnitudes, with the sign applied to
//     a nonzero quotient at the end.
//   Latency is fixed at 33 edges from the start edge to the result edge, for
//   every operation and operand (divide-by-zero included).
//
// Handshake
//   A start is a one-cycle pulse on ctrl_MULT or ctrl_DIV; no ready is
//   returned. MULT wins when both are high. A start in any state aborts the
//   operation in flight and begins a new one with freshly sampled operands.
//   An aborted operation never pulses data_resultRDY.
//   busy is high from the cycle after the start edge up to and including the
//   cycle before the result edge. data_resultRDY is a one-cycle pulse in the
//   cycle after the result edge, with busy low in that cycle.
//   data_result and data_exception hold until the next completion.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   ctrl_MULT       in   one-cycle multiply start pulse
//   ctrl_DIV        in   one-cycle divide start pulse
//   data_operandA   in   multiplicand / dividend (two's complement)
//   data_operandB   in   multiplier / divisor (two's complement)
//   data_result     out  registered result
//   data_exception  out  registered overflow / divide-by-zero flag
//   data_resultRDY  out  one-cycle completion pulse
//   busy            out  operation in progress
//   dbg_state_o     out  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
// -----------------------------------------------------------------------------
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q;
  logic [4:0]           cnt_q;
  logic                 is_div_q;
  logic                 neg_q;     // sign of the final result (sA ^ sB)
  logic                 div0_q;    // divisor was zero
  logic                 ovf_q;     // MIN_NEG / -1
  logic [2*WIDTH-1:0]   acc_q;     // product accumulator (magnitude)
  logic [2*WIDTH-1:0]   mcand_q;   // multiplicand magnitude, shifted left per step
  logic [WIDTH-1:0]     mplier_q;  // MUL: multiplier magnitude; DIV: dividend in / quotient out
  logic [WIDTH-1:0]     rem_q;     // partial remainder
  logic [WIDTH-1:0]     dvsr_q;    // divisor magnitude
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic                 rdy_q;
  logic                 busy_q;

  // ---------------------------------------------------------------------------
  // Operand magnitudes at the start cycle. Negating MIN_NEG gives MIN_NEG,
  // which is exactly 2^31 when read as unsigned, so no extra bit is needed.
  // ---------------------------------------------------------------------------
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = data_operandA[WIDTH-1];
  assign b_neg = data_operandB[WIDTH-1];
  assign a_mag = a_neg ? -data_operandA : data_operandA;
  assign b_mag = b_neg ? -data_operandB : data_operandB;

  // ---------------------------------------------------------------------------
  // One iteration of each datapath
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;

  assign mul_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Bring the next dividend bit into the remainder and try the subtraction;
  // a clear borrow bit means the divisor fit. The remainder stays below the
  // divisor (at most 2^31), so the shifted value always fits in WIDTH+1 bits.
  assign div_shift = {rem_q, mplier_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvsr_q};
  assign div_ok    = ~div_trial[WIDTH];

  // ---------------------------------------------------------------------------
  // Final sign fix-up and exception, consumed in DONE
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   result_d;
  logic               exc_d;

  always_comb begin
    prod_signed = neg_q ? -acc_q : acc_q;
    quo_signed  = (neg_q && (mplier_q != '0)) ? -mplier_q : mplier_q;
    result_d    = '0;
    exc_d       = 1'b0;
    if (is_div_q) begin
      if (div0_q) begin
        result_d = '0;
        exc_d    = 1'b1;
      end else if (ovf_q) begin
        result_d = MIN_NEG;
        exc_d    = 1'b1;
      end else begin
        result_d = quo_signed;
        exc_d    = 1'b0;
      end
    end else begin
      result_d = prod_signed[WIDTH-1:0];
      // The product fits in signed WIDTH bits only when bits [2W-1:W-1]
      // are a pure sign extension.
      exc_d    = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) |
                   ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        // Start or restart from any state; the in-flight op is dropped.
        state_q  <= ctrl_MULT ? ST_MUL : ST_DIV;
        is_div_q <= ~ctrl_MULT;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
        neg_q    <= a_neg ^ b_neg;
        div0_q   <= (data_operandB == '0);
        ovf_q    <= (data_operandA == MIN_NEG) && (data_operandB == ALL_ONE);
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
        mplier_q <= ctrl_MULT ? b_mag : a_mag;
        rem_q    <= '0;
        dvsr_q   <= b_mag;
      end else begin
        case (state_q)
          ST_MUL: begin
            acc_q    <= mul_acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= ST_DONE;
          end
          ST_DIV: begin
            rem_q    <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            mplier_q <= {mplier_q[WIDTH-2:0], div_ok};
            cnt_q    <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= ST_DONE;
          end
          ST_DONE: begin
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//   Directed and random checks of multdiv_unit. Each start with a result to
//   wait for pushes its expected {exception, result} and expected ready cycle
//   into a queue; a monitor pops and compares on every data_resultRDY pulse.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

  localparam int W = 33;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [1:0]  dbg_state_o;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  last_result = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: signed 64-bit product, or truncating signed divide.
  function automatic logic [W-1:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    logic [31:0] q;
    if (!is_div) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pu = p;
      return {(pu[63:31] != {33{pu[31]}}), pu[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  // Monitor
  logic         prev_rdy  = 1'b0;
  logic         prev_busy = 1'b0;
  logic [W-1:0] mon_exp;
  int           mon_cyc;

  always @(negedge clock) begin
    if (data_resultRDY) begin
      check("rdy_not_consecutive", prev_rdy, 0);
      check("busy_low_at_rdy", busy, 0);
      check("busy_high_before_rdy", prev_busy, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("result", data_result, mon_exp[31:0]);
        check("exception", data_exception, mon_exp[32]);
        check("latency", cyc, mon_cyc);
        last_result = mon_exp[31:0];
      end
    end
    prev_rdy  = data_resultRDY;
    prev_busy = busy;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called between a negedge and the next posedge)
  // mode: 0 = MULT, 1 = DIV, 2 = both strobes together
  // ---------------------------------------------------------------------------
  task automatic start_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_it);
    ctrl_MULT     = (mode != 1);
    ctrl_DIV      = (mode != 0);
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (expect_it) begin
      exp_q.push_back(model(mode == 1, a, b));
      exp_cyc_q.push_back(cyc + 33);
    end
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          mode;
    logic [31:0] a, b;

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 0);
    check("rst_exception", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state_o, 0);
    reset = 1'b0;
    @(negedge clock);

    // Multiply
    start_op(0, 32'd7, 32'hFFFF_FFFD, 1);
    wait_done();
    @(negedge clock);
    check("hold_result", data_result, 32'hFFFF_FFEB);
    check("rdy_single_cycle", data_resultRDY, 0);
    check("busy_idle", busy, 0);

    start_op(0, 32'h0001_0000, 32'h0001_0000, 1);
    wait_done();
    start_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done();
    start_op(0, 32'hFFFF_0000, 32'h0000_8000, 1);
    wait_done();

    // Divide
    start_op(1, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done();
    start_op(1, 32'd100, 32'd7, 1);
    wait_done();
    start_op(1, 32'd5, 32'd0, 1);
    wait_done();
    start_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done();
    start_op(1, 32'd3, 32'hFFFF_FFF6, 1);
    wait_done();

    // Restart: divide aborted by a multiply 10 cycles later
    start_op(1, 32'd100, 32'd7, 0);
    repeat (9) @(negedge clock);
    start_op(0, 32'd6, 32'd7, 1);
    wait_done();

    // Both strobes together: multiply wins
    @(negedge clock);
    start_op(2, 32'd9, 32'd3, 1);
    wait_done();

    // New start in the ready cycle; completed result must stay valid
    @(negedge clock);
    start_op(0, 32'd123, 32'hFFFF_FE38, 1);
    wait_done();
    start_op(1, 32'hFFFF_FC18, 32'd7, 1);
    check("hold_after_b2b_start", data_result, last_result);
    check("no_rdy_after_b2b_start", data_resultRDY, 0);
    wait_done();

    // Random mix
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      mode = $urandom_range(0, 1);
      a    = $urandom;
      b    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 1) a = a >>> $urandom_range(0, 24);
      start_op(mode, a, b, 1);
      wait_done();
    end

    // Reset in the middle of a multiply: outputs clear, no ready follows
    @(negedge clock);
    start_op(0, 32'h0000_1234, 32'h0000_5678, 0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    check("midrst_result", data_result, 0);
    check("midrst_exception", data_exception, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state_o, 0);
    repeat (40) @(negedge clock);
    check("midrst_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multicycle signed 32-bit multiplier/divider for the execute stage. It is started by the one-cycle `is_mul` / `is_div` strobes from the ALU decode path. It returns a result with a fixed latency and raises an exception flag on overflow or divide-by-zero. The pipeline stalls on `busy` and writes back `data_result` when `data_resultRDY` pulses.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-high.
- `ctrl_MULT`, input, 1: one-cycle start pulse for multiply (driven from `is_mul`).
- `ctrl_DIV`, input, 1: one-cycle start pulse for divide (driven from `is_div`).
- `data_operandA`, input, 32: multiplicand / dividend (two's complement). Sampled only on a start cycle.
- `data_operandB`, input, 32: multiplier / divisor (two's complement). Sampled only on a start cycle.
- `data_result`, output, 32: registered result. Holds its value until the next completion.
- `data_exception`, output, 1: registered exception flag. Updated together with `data_result`.
- `data_resultRDY`, output, 1: one-cycle completion pulse.
- `busy`, output, 1: high from the cycle after a start through the cycle before `data_resultRDY`.

## Operation
- States:
  - IDLE: waits for a start pulse.
  - MUL: 32-step shift-add on magnitudes, or radix-2 Booth on signed values. Implementer's choice, but the result must be bit-identical to the rules below.
  - DIV: 32-step restoring divide on magnitudes, with sign fix-up.
  - DONE: registers the result and pulses ready.
- 5-bit step counter, cleared on start. MUL/DIV move to DONE when the counter reaches 31 and that step completes. DONE always returns to IDLE on the next edge.
- Start priority:
  - If `ctrl_MULT` and `ctrl_DIV` are high in the same cycle, MULT wins and DIV is ignored.
  - A start pulse in any state, including MUL, DIV or DONE, aborts the current operation and restarts with freshly sampled operands. An aborted operation never asserts `data_resultRDY`.
- Multiply rules:
  - `data_result` is the low 32 bits of the full signed 64-bit product.
  - `data_exception` = 1 iff product bits [63:31] are not all equal, i.e. the product does not fit in signed 32 bits.
- Divide rules:
  - Quotient truncates toward zero. The remainder is discarded.
  - Quotient sign = sign(A) XOR sign(B), applied only to a nonzero quotient.
  - Divisor 0: `data_result` = 0, `data_exception` = 1. The operation still runs the full latency.
  - A = 0x80000000, B = 0xFFFFFFFF: `data_result` = 0x80000000, `data_exception` = 1.
  - All other divides: `data_exception` = 0.
- Operand and sign state is internal. External operand changes after the start cycle have no effect.

## Timing
- Reset values: state IDLE, counter 0, `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0.
- Reset is asserted in any state: the next edge forces all reset values and discards any in-flight operation. Reset dominates a simultaneous start pulse.
- Let the start pulse be sampled at edge E0. Then:
  - `busy` is high from after E0 through after E32.
  - `data_result` and `data_exception` update at E33.
  - `data_resultRDY` is high for exactly the cycle following E33.
  - `busy` is low in that same cycle.
- Latency is fixed at 33 cycles, start edge to result edge, for both operations and all operands, including divide-by-zero.
- A new start may be issued in the same cycle that `data_resultRDY` is high. The completed result stays valid; the new operation begins at that edge.
- A start while busy resets the timeline: the new E0 is the restart edge.
- `data_resultRDY` is never high for two consecutive cycles.

## Test plan
- MULT A = 7, B = −3 (0xFFFFFFFD) -> after 33 cycles `data_result` = 0xFFFFFFEB, `data_exception` = 0, single-cycle `data_resultRDY`.
- MULT A = 0x00010000, B = 0x00010000 -> `data_result` = 0x00000000, `data_exception` = 1.
- DIV cases:
  - A = −7, B = 2 -> `data_result` = 0xFFFFFFFD (−3), `data_exception` = 0.
  - A = 100, B = 7 -> `data_result` = 14, `data_exception` = 0.
- DIV A = 5, B = 0 -> `data_result` = 0, `data_exception` = 1, ready exactly 33 cycles after start.
- Restart: DIV 100/7 started, then MULT 6×7 issued 10 cycles later. Expect no ready pulse for the divide, `data_resultRDY` 33 cycles after the MULT start, and `data_result` = 42.
- Control edge cases:
  - `ctrl_MULT` and `ctrl_DIV` together with A = 9, B = 3 -> `data_result` = 27.
  - `reset` asserted mid-multiply -> all outputs 0 on the next cycle, and no ready pulse follows.
